// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier datapath stages.
// Holds the partial-product accumulator state encoding and the term order.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } ppa_state_t;

  localparam int PPA_NUM_TERMS = 6;

  localparam int IDX_AHBH = 0;
  localparam int IDX_AHBL = 1;
  localparam int IDX_ALBH = 2;
  localparam int IDX_ALBL = 3;
  localparam int IDX_EVA  = 4;
  localparam int IDX_EVB  = 5;

endpackage

// File: rtl/ppa_term_select.sv
// Combinational N:1 mux picking the term register addressed by the
// accumulator's term counter; out-of-range selects yield zero.
module ppa_term_select #(
  parameter int WIDTH     = 32,
  parameter int NUM_TERMS = 6,
  parameter int SEL_W     = 3
) (
  input  logic [NUM_TERMS-1:0][WIDTH-1:0] terms_i,
  input  logic [SEL_W-1:0]                sel_i,
  output logic [WIDTH-1:0]                term_o
);

  always_comb begin
    // NOTE: defaulting the output before the loop keeps every path assigned, so no latch is inferred.
    term_o = '0;
    for (int i = 0; i < NUM_TERMS; i++) begin
      if (sel_i == SEL_W'(i)) term_o = terms_i[i];
    end
  end

endmodule

// File: rtl/partial_product_accumulator.sv
// Sums six pre-extended partial products / correction terms with one adder,
// one term per cycle. Optional carry_o port under PPA_CARRY_OUT_EN.
module partial_product_accumulator
  import mult_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_TERMS = PPA_NUM_TERMS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] ahbh_i,
  input  logic [WIDTH-1:0] ahbl_i,
  input  logic [WIDTH-1:0] albh_i,
  input  logic [WIDTH-1:0] albl_i,
  input  logic [WIDTH-1:0] eva_i,
  input  logic [WIDTH-1:0] evb_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] product_o
`ifdef PPA_CARRY_OUT_EN
  ,
  output logic             carry_o
`endif
);

  localparam int CNT_W = $clog2(NUM_TERMS);
`ifdef PPA_CARRY_OUT_EN
  localparam int ACC_W = WIDTH + 3;
`else
  localparam int ACC_W = WIDTH;
`endif

  ppa_state_t                     state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [ACC_W-1:0]               acc_q, acc_d;
  logic [NUM_TERMS-1:0][WIDTH-1:0] terms_q, terms_d;
  logic [WIDTH-1:0]               term_sel;

  ppa_term_select #(
    .WIDTH    (WIDTH),
    .NUM_TERMS(NUM_TERMS),
    .SEL_W    (CNT_W)
  ) u_term_select (
    .terms_i(terms_q),
    .sel_i  (cnt_q),
    .term_o (term_sel)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    terms_d = terms_q;

    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            terms_d[IDX_AHBH] = ahbh_i;
            terms_d[IDX_AHBL] = ahbl_i;
            terms_d[IDX_ALBH] = albh_i;
            terms_d[IDX_ALBL] = albl_i;
            terms_d[IDX_EVA]  = eva_i;
            terms_d[IDX_EVB]  = evb_i;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          // Terms are zero-extended: any overflow above WIDTH lands in the carry bits.
          acc_d = acc_q + ACC_W'(term_sel);
          if (cnt_q == CNT_W'(NUM_TERMS - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (ready_i) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end
      endcase
    end
  end

  // NOTE: the term registers are few and feed the output path, so they are reset like the rest of the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      terms_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      terms_q <= terms_d;
    end
  end

  assign ready_o   = (state_q == IDLE);
  assign valid_o   = (state_q == DONE);
  assign product_o = acc_q[WIDTH-1:0];
`ifdef PPA_CARRY_OUT_EN
  assign carry_o   = valid_o & (|acc_q[WIDTH+2:WIDTH]);
`endif

endmodule

// File: tb/tb_partial_product_accumulator.sv
// Directed self-checking bench for partial_product_accumulator; carry_o
// checks are compiled in when PPA_CARRY_OUT_EN is defined.
module tb_partial_product_accumulator;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         clear_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] ahbh_i = '0, ahbl_i = '0, albh_i = '0, albl_i = '0, eva_i = '0, evb_i = '0;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic [W-1:0] product_o;
`ifdef PPA_CARRY_OUT_EN
  logic         carry_o;
`endif

  partial_product_accumulator #(.WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (clear_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .ahbh_i   (ahbh_i),
    .ahbl_i   (ahbl_i),
    .albh_i   (albh_i),
    .albl_i   (albl_i),
    .eva_i    (eva_i),
    .evb_i    (evb_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .product_o(product_o)
`ifdef PPA_CARRY_OUT_EN
    ,
    .carry_o  (carry_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [5:0][W-1:0] t;
    logic [W-1:0]      exp_p;
    logic              exp_c;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [W-1:0] a, b, c, d, e, f, p, input logic cy);
    vec_t v;
    v.t[0] = a; v.t[1] = b; v.t[2] = c; v.t[3] = d; v.t[4] = e; v.t[5] = f;
    v.exp_p = p;
    v.exp_c = cy;
    return v;
  endfunction

  task automatic drive_terms(input vec_t v);
    ahbh_i = v.t[0]; ahbl_i = v.t[1]; albh_i = v.t[2];
    albl_i = v.t[3]; eva_i  = v.t[4]; evb_i  = v.t[5];
  endtask

  task automatic scramble_terms();
    ahbh_i = $urandom; ahbl_i = $urandom; albh_i = $urandom;
    albl_i = $urandom; eva_i  = $urandom; evb_i  = $urandom;
  endtask

  // Accept on the next rising edge, then corrupt the inputs to prove they are ignored.
  task automatic accept(input vec_t v);
    @(negedge clk_i);
    check("ready_before_accept", ready_o, 1);
    drive_terms(v);
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    scramble_terms();
    check("ready_in_accum", ready_o, 0);
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int lat;
    lat = 1;
    @(posedge clk_i);
    #1;
    while (!valid_o && lat < 20) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    check(name, lat, exp_lat);
  endtask

  task automatic check_result(input string name, input vec_t v);
    check({name, "_valid"}, valid_o, 1);
    check({name, "_product"}, product_o, v.exp_p);
`ifdef PPA_CARRY_OUT_EN
    check({name, "_carry"}, carry_o, v.exp_c);
`endif
  endtask

  task automatic release_result(input string name);
    @(negedge clk_i);
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    check({name, "_valid_drop"}, valid_o, 0);
    check({name, "_ready_back"}, ready_o, 1);
  endtask

  vec_t vecs[7];
  vec_t vc, vr;
  logic [W-1:0] held;

  initial begin
    vecs[0] = mk(32'h0001_0000, 32'h0000_0100, 32'h0000_0100, 32'h0000_0001, 0, 0, 32'h0001_0201, 1'b0);
    vecs[1] = mk(32'h0000_0002, 0, 0, 32'hFFFF_FFFF, 0, 0, 32'h0000_0001, 1'b1);
    vecs[2] = mk(32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 32'h0000_0000, 1'b1);
    vecs[3] = mk('1, '1, '1, '1, '1, '1, 32'hFFFF_FFFA, 1'b1);
    vecs[4] = mk(1, 2, 3, 4, 5, 6, 32'h0000_0015, 1'b0);
    vecs[5] = mk(32'h1234_5678, 32'h1111_1111, 0, 0, 0, 0, 32'h2345_6789, 1'b0);
    vecs[6] = mk(0, 0, 0, 0, 7, 32'hFFFF_FFF9, 32'h0000_0000, 1'b1);

    // Reset state
    #12;
    check("rst_ready", ready_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_product", product_o, 0);
`ifdef PPA_CARRY_OUT_EN
    check("rst_carry", carry_o, 0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Table-driven operations with latency check
    for (int i = 0; i < 7; i++) begin
      accept(vecs[i]);
      wait_valid($sformatf("v%0d_latency", i), 6);
      check_result($sformatf("v%0d", i), vecs[i]);
      release_result($sformatf("v%0d", i));
    end

    // Backpressure: result held for 3 cycles
    accept(vecs[0]);
    wait_valid("bp_latency", 6);
    held = product_o;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i);
      #1;
      check("bp_valid_hold", valid_o, 1);
      check("bp_product_hold", product_o, held);
      check("bp_ready_low", ready_o, 0);
    end
    check("bp_product_value", held, vecs[0].exp_p);
    release_result("bp");

    // valid_i together with clear_i in IDLE is not accepted
    @(negedge clk_i);
    drive_terms(vecs[4]);
    valid_i = 1'b1;
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    clear_i = 1'b0;
    check("clr_idle_no_accept", ready_o, 1);

    // clear_i two cycles into ACCUM
    vc = mk(32'hDEAD_0000, 32'h0000_BEEF, 32'h1000_0000, 0, 0, 0, 32'hEEAD_BEEF, 1'b0);
    accept(vc);
    @(posedge clk_i);
    @(negedge clk_i);
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    check("clr_accum_ready", ready_o, 1);
    check("clr_accum_valid", valid_o, 0);
    check("clr_accum_acc", product_o, 0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk_i);
        #1;
        if (valid_o) seen++;
      end
      check("clr_no_valid_after", seen, 0);
    end
    accept(vecs[4]);
    wait_valid("clr_next_latency", 6);
    check_result("clr_next", vecs[4]);
    release_result("clr_next");

    // Reset mid-ACCUM
    accept(vecs[5]);
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_accum_ready", ready_o, 1);
    check("rst_accum_valid", valid_o, 0);
    check("rst_accum_product", product_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Reset mid-DONE
    accept(vecs[3]);
    wait_valid("rst_done_latency", 6);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_done_valid", valid_o, 0);
    check("rst_done_product", product_o, 0);
    check("rst_done_ready", ready_o, 1);
`ifdef PPA_CARRY_OUT_EN
    check("rst_done_carry", carry_o, 0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Clean operation after reset
    vr = mk(5, 0, 0, 0, 0, 32'h0000_0010, 32'h0000_0015, 1'b0);
    accept(vr);
    wait_valid("post_rst_latency", 6);
    check_result("post_rst", vr);
    release_result("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
